// File: rtl/mvt_pkg.sv
// Shared constants and types for the MVT sequencer and its pipes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mvt_pkg;

    // Default geometry and pipeline depths of the MVT datapath.
    localparam int N        = 100;
    localparam int ADDR_W   = 14;
    localparam int IDX_W    = 7;
    localparam int MEM_LAT  = 1;
    localparam int MAC_LAT  = 2;
    localparam int AT_TRANS = 1;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mvt_state_e;

    // Per-element MAC control flags travelling alongside the memory read.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } mac_flags_t;

endpackage

// File: rtl/mvt_delay_line.sv
// Fixed-depth shift register that clears on reset; used to align control with data.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle, upstream inserts bubbles itself.
module mvt_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    import mvt_pkg::*;

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Next stage contents: new input at the head, everything else moves one down.
    always_comb begin
        stage_d[0] = din;
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    // Pipeline registers; reset empties the whole line so no stale strobes escape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mvt_sequencer.sv
// Walks (i,j) over an N x N matrix, issuing A/At/y reads and aligned MAC and x write-back controls.
// Latency: first issue 1 cycle after start; mac_* MEM_LAT after issue; x_wr_en MAC_LAT after mac_last.
// Backpressure: stall freezes issue (counters/addresses hold) and injects a bubble into the flag pipe.
module mvt_sequencer #(
    parameter int N        = mvt_pkg::N,
    parameter int ADDR_W   = mvt_pkg::ADDR_W,
    parameter int IDX_W    = mvt_pkg::IDX_W,
    parameter int MEM_LAT  = mvt_pkg::MEM_LAT,
    parameter int MAC_LAT  = mvt_pkg::MAC_LAT,
    parameter int AT_TRANS = mvt_pkg::AT_TRANS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] at_addr,
    output logic [IDX_W-1:0]  y_idx,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic              x_wr_en,
    output logic [IDX_W-1:0]  x_wr_idx
);
    import mvt_pkg::*;

    // The pipe behind the last issue is MEM_LAT deep for data plus MAC_LAT for the MAC.
    localparam int                DRAIN_CYC  = MEM_LAT + MAC_LAT;
    localparam int                CNT_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0]  DRAIN_INIT = CNT_W'(DRAIN_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  I_ONE      = IDX_W'(1);
    localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STRIDE   = ADDR_W'(N);
    localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);

    mvt_state_e        state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] at_addr_q, at_addr_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              issue;
    logic              row_end;
    logic              last_elem;

    // Flag pipe carries the MAC flags plus the row index down to the MAC.
    mac_flags_t        iss_flags;
    logic [IDX_W-1:0]  iss_row;
    mac_flags_t        mac_flags;
    logic [IDX_W-1:0]  mac_row;

    // Write-back pipe carries the row-complete strobe through the MAC latency.
    logic              wb_in_vld;
    logic [IDX_W-1:0]  wb_in_row;

    // An element goes out only while running and the memories are ready.
    assign issue     = (state_q == ST_RUN) && !stall;
    assign row_end   = (j_q == LAST_IDX);
    assign last_elem = row_end && (i_q == LAST_IDX);

    // Next-state, counter and address update; addresses step by addition only.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        a_addr_d  = a_addr_q;
        at_addr_d = at_addr_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                    i_d       = '0;
                    j_d       = '0;
                    a_addr_d  = '0;
                    at_addr_d = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    a_addr_d = a_addr_q + A_ONE;
                    if (row_end) begin
                        j_d = '0;
                        i_d = i_q + I_ONE;
                        // Column-wise walk restarts at the top of the next column.
                        at_addr_d = (AT_TRANS != 0) ? (a_addr_q + A_ONE)
                                                    : (ADDR_W'(i_q) + A_ONE);
                    end else begin
                        j_d = j_q + I_ONE;
                        at_addr_d = (AT_TRANS != 0) ? (a_addr_q + A_ONE)
                                                    : (at_addr_q + A_STRIDE);
                    end
                    if (last_elem) begin
                        // Park counters at the origin so the next pass starts clean.
                        state_d   = ST_DRAIN;
                        drain_d   = DRAIN_INIT;
                        i_d       = '0;
                        j_d       = '0;
                        a_addr_d  = '0;
                        at_addr_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - C_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, counters, addresses and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            a_addr_q  <= '0;
            at_addr_q <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            a_addr_q  <= a_addr_d;
            at_addr_q <= at_addr_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Flags for the element being issued; all zero on a bubble.
    always_comb begin
        iss_flags.vld   = issue;
        iss_flags.first = issue && (j_q == '0);
        iss_flags.last  = issue && row_end;
        iss_row         = issue ? i_q : '0;
    end

    mvt_delay_line #(
        .W     ($bits(mac_flags_t) + IDX_W),
        .DEPTH (MEM_LAT)
    ) u_flag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({iss_flags, iss_row}),
        .dout  ({mac_flags, mac_row})
    );

    // A row finishes when its last product reaches the MAC.
    always_comb begin
        wb_in_vld = mac_flags.vld && mac_flags.last;
        wb_in_row = wb_in_vld ? mac_row : '0;
    end

    mvt_delay_line #(
        .W     (1 + IDX_W),
        .DEPTH (MAC_LAT)
    ) u_wb_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({wb_in_vld, wb_in_row}),
        .dout  ({x_wr_en, x_wr_idx})
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_en    = issue;
    assign a_addr    = a_addr_q;
    assign at_addr   = at_addr_q;
    assign y_idx     = j_q;
    assign mac_valid = mac_flags.vld;
    assign mac_first = mac_flags.first;
    assign mac_last  = mac_flags.last;

endmodule

// File: tb/tb_mvt_sequencer.sv
// Bench for mvt_sequencer: three instances (N=4 At transposed, N=4 column-wise At, N=1).
// A pass-level model predicts every output each cycle; literal checks pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_mvt_sequencer;

    localparam int AW = 14;
    localparam int IW = 7;
    localparam int ML = 1;
    localparam int XL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rstn_i, start_i, stall_i;
    logic [2:0] busy_o, done_o, mem_en_o, mac_valid_o, mac_first_o, mac_last_o, x_wr_en_o;
    logic [AW-1:0] a_addr_o  [3];
    logic [AW-1:0] at_addr_o [3];
    logic [IW-1:0] y_idx_o   [3];
    logic [IW-1:0] x_wr_idx_o[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mvt_sequencer #(
            .N        ((g == 2) ? 1 : 4),
            .ADDR_W   (AW),
            .IDX_W    (IW),
            .MEM_LAT  (ML),
            .MAC_LAT  (XL),
            .AT_TRANS ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rstn_i[g]),
            .start     (start_i[g]),
            .stall     (stall_i[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .mem_en    (mem_en_o[g]),
            .a_addr    (a_addr_o[g]),
            .at_addr   (at_addr_o[g]),
            .y_idx     (y_idx_o[g]),
            .mac_valid (mac_valid_o[g]),
            .mac_first (mac_first_o[g]),
            .mac_last  (mac_last_o[g]),
            .x_wr_en   (x_wr_en_o[g]),
            .x_wr_idx  (x_wr_idx_o[g])
        );
    end

    function automatic int cfg_n(input int m);
        return (m == 2) ? 1 : 4;
    endfunction

    function automatic int cfg_at(input int m);
        return (m == 1) ? 0 : 1;
    endfunction

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Pass-level model: issue count k, pass flag, done cycle, and which element issued each cycle.
    bit in_pass [3] = '{default: 1'b0};
    int k       [3] = '{default: 0};
    int t_done  [3] = '{default: -1};
    int hist    [3][16] = '{default: '{default: -1}};

    // Observation logs for the literal checks.
    int a_log  [3][32];
    int at_log [3][32];
    int wr_log [3][8];
    int n_iss[3], n_wr[3], n_mv[3], n_fl[3], n_done[3];
    int mv_first[3], mv_last[3], done_cyc[3], last_wr_cyc[3];
    int fmask[3], lmask[3];

    task automatic chk(input string nm, input int m, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [u%0d] cycle %0d: got %0d, expected %0d", nm, m, cyc, act, exp);
        end
    endtask

    task automatic clr_log(input int m);
        n_iss[m] = 0; n_wr[m] = 0; n_mv[m] = 0; n_fl[m] = 0; n_done[m] = 0;
        mv_first[m] = -1; mv_last[m] = -1; done_cyc[m] = -1; last_wr_cyc[m] = -1;
        fmask[m] = 0; lmask[m] = 0;
    endtask

    task automatic model_cycle(input int m);
        int n, nn, e, hm, hw;
        bit running, ex_me, ex_done;
        n  = cfg_n(m);
        nn = n * n;
        if (!rstn_i[m]) begin
            in_pass[m] = 1'b0;
            k[m]       = 0;
            t_done[m]  = -1;
            for (int s = 0; s < 16; s++) hist[m][s] = -1;
        end
        running = in_pass[m] && (k[m] < nn);
        ex_me   = running && !stall_i[m] && rstn_i[m];
        ex_done = in_pass[m] && (t_done[m] >= 0) && (cyc == t_done[m]);
        e  = k[m] % nn;
        hm = hist[m][(cyc - ML) & 15];
        hw = hist[m][(cyc - ML - XL) & 15];

        chk("busy",      m, int'(busy_o[m]),      int'(in_pass[m] && !ex_done));
        chk("done",      m, int'(done_o[m]),      int'(ex_done));
        chk("mem_en",    m, int'(mem_en_o[m]),    int'(ex_me));
        chk("a_addr",    m, int'(a_addr_o[m]),    e);
        chk("at_addr",   m, int'(at_addr_o[m]),   (cfg_at(m) != 0) ? e : (e % n) * n + e / n);
        chk("y_idx",     m, int'(y_idx_o[m]),     e % n);
        chk("mac_valid", m, int'(mac_valid_o[m]), int'(hm >= 0));
        chk("mac_first", m, int'(mac_first_o[m]), int'(hm >= 0 && hm % n == 0));
        chk("mac_last",  m, int'(mac_last_o[m]),  int'(hm >= 0 && hm % n == n - 1));
        chk("x_wr_en",   m, int'(x_wr_en_o[m]),   int'(hw >= 0 && hw % n == n - 1));
        chk("x_wr_idx",  m, int'(x_wr_idx_o[m]),  (hw >= 0 && hw % n == n - 1) ? hw / n : 0);

        if (mem_en_o[m] && n_iss[m] < 32) begin
            a_log[m][n_iss[m]]  = int'(a_addr_o[m]);
            at_log[m][n_iss[m]] = int'(at_addr_o[m]);
            n_iss[m]++;
        end
        if (mac_valid_o[m]) begin
            if (mv_first[m] < 0) mv_first[m] = cyc;
            mv_last[m] = cyc;
            if (mac_first_o[m] && n_mv[m] < 32) fmask[m] |= (1 << n_mv[m]);
            if (mac_last_o[m] && n_mv[m] < 32)  lmask[m] |= (1 << n_mv[m]);
            if (mac_first_o[m] && mac_last_o[m]) n_fl[m]++;
            n_mv[m]++;
        end
        if (x_wr_en_o[m]) begin
            if (n_wr[m] < 8) wr_log[m][n_wr[m]] = int'(x_wr_idx_o[m]);
            n_wr[m]++;
            last_wr_cyc[m] = cyc;
        end
        if (done_o[m]) begin
            n_done[m]++;
            done_cyc[m] = cyc;
        end

        if (rstn_i[m]) begin
            hist[m][cyc & 15] = ex_me ? k[m] : -1;
            if (ex_me) begin
                k[m]++;
                if (k[m] == nn) t_done[m] = cyc + ML + XL + 1;
            end
            if (ex_done) begin
                in_pass[m] = 1'b0;
            end else if (!in_pass[m] && start_i[m]) begin
                in_pass[m] = 1'b1;
                k[m]       = 0;
                t_done[m]  = -1;
            end
        end
    endtask

    // Single compare process: every output of every instance, every cycle.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) model_cycle(m);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int m);
        start_i[m] = 1'b1;
        tick(1);
        start_i[m] = 1'b0;
    endtask

    task automatic wait_done(input int m, input int budget);
        int c;
        c = 0;
        while (!done_o[m] && c < budget) begin
            tick(1);
            c++;
        end
        chk("wait_done_timeout", m, int'(done_o[m]), 1);
    endtask

    task automatic wait_addr(input int m, input int addr, input int budget);
        int c;
        c = 0;
        while (!(busy_o[m] && int'(a_addr_o[m]) == addr) && c < budget) begin
            tick(1);
            c++;
        end
        chk("wait_addr_timeout", m, int'(a_addr_o[m]), addr);
    endtask

    int exp_at_col [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    initial begin
        for (int m = 0; m < 3; m++) clr_log(m);
        rstn_i  = '0;
        start_i = '0;
        stall_i = '0;
        tick(3);
        rstn_i = '1;

        // Idle after reset with no start.
        tick(20);
        for (int m = 0; m < 3; m++) begin
            chk("idle_busy", m, int'(busy_o[m]), 0);
            chk("idle_mem_en", m, int'(mem_en_o[m]), 0);
        end

        // One clean pass on all three instances together.
        for (int m = 0; m < 3; m++) clr_log(m);
        start_i = '1;
        tick(1);
        start_i = '0;
        wait_done(0, 100);
        // A start landing in the done cycle is dropped.
        start_i[0] = 1'b1;
        tick(1);
        start_i[0] = 1'b0;
        tick(4);
        chk("start_in_done_ignored", 0, int'(busy_o[0]), 0);
        chk("u0_issues", 0, n_iss[0], 16);
        for (int i = 0; i < 16; i++) begin
            chk("u0_a_seq", 0, a_log[0][i], i);
            chk("u0_at_seq", 0, at_log[0][i], i);
            chk("u1_a_seq", 1, a_log[1][i], i);
            chk("u1_at_col_seq", 1, at_log[1][i], exp_at_col[i]);
        end
        chk("u0_first_mask", 0, fmask[0], 32'h1111);
        chk("u0_last_mask", 0, lmask[0], 32'h8888);
        chk("u0_writes", 0, n_wr[0], 4);
        for (int i = 0; i < 4; i++) chk("u0_wr_order", 0, wr_log[0][i], i);
        chk("u0_done_after_wr", 0, done_cyc[0] - last_wr_cyc[0], 1);
        chk("u0_done_count", 0, n_done[0], 1);
        chk("u2_issues", 2, n_iss[2], 1);
        chk("u2_first_and_last", 2, n_fl[2], 1);
        chk("u2_writes", 2, n_wr[2], 1);
        chk("u2_wr_idx", 2, wr_log[2][0], 0);
        chk("u2_done_count", 2, n_done[2], 1);

        // Three-cycle stall on the row-end element (1,3), plus a start while busy.
        clr_log(0);
        pulse_start(0);
        tick(2);
        pulse_start(0);
        wait_addr(0, 7, 40);
        stall_i[0] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("stall_hold_a", 0, int'(a_addr_o[0]), 7);
            chk("stall_hold_at", 0, int'(at_addr_o[0]), 7);
            tick(1);
        end
        stall_i[0] = 1'b0;
        wait_done(0, 100);
        tick(2);
        chk("stall_mac_span", 0, mv_last[0] - mv_first[0] + 1, 19);
        chk("stall_mac_count", 0, n_mv[0], 16);
        chk("stall_writes", 0, n_wr[0], 4);
        for (int i = 0; i < 4; i++) chk("stall_wr_order", 0, wr_log[0][i], i);
        chk("stall_done_count", 0, n_done[0], 1);

        // Reset mid-run at (2,1), then a fresh pass from the origin.
        clr_log(0);
        pulse_start(0);
        wait_addr(0, 9, 40);
        rstn_i[0] = 1'b0;
        #1;
        chk("rst_busy", 0, int'(busy_o[0]), 0);
        chk("rst_mem_en", 0, int'(mem_en_o[0]), 0);
        chk("rst_a_addr", 0, int'(a_addr_o[0]), 0);
        tick(2);
        rstn_i[0] = 1'b1;
        tick(10);
        chk("rst_no_done", 0, n_done[0], 0);
        chk("rst_no_restart", 0, int'(busy_o[0]), 0);
        clr_log(0);
        pulse_start(0);
        wait_done(0, 100);
        tick(2);
        chk("restart_first_addr", 0, a_log[0][0], 0);
        chk("restart_issues", 0, n_iss[0], 16);
        chk("restart_writes", 0, n_wr[0], 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
